alu_iter: RTL and testbench

- Multi-cycle ALU responder for the `alu_test`-style request/result handshake, which has an initiator on the other side.
- Accepts one operand pair plus a 3-bit command, computes the result, and returns it with a one-cycle valid pulse.
- Shifts, add and sub finish in one cycle. MUL uses an iterative shift-add unit and DIV uses an iterative restoring divider; each takes WIDTH iteration cycles.
- Sits between the CPU execute stage (or a bench) and the register write-back.

---
 rtl/alu_iter.sv | 111 +++++++++++
 tb/tb_alu_iter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU responder with single-cycle shifts/add/sub and iterative MUL/DIV
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_cmd,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid,
  output logic             o_ready,
  output logic             o_div_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_SHL = 3'd1, OP_SHR = 3'd2, OP_SHRA = 3'd3, OP_ADD = 3'd4,
                         OP_SUB = 3'd5, OP_MUL = 3'd6, OP_DIV = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic dz_q, dz_d;
  logic [WIDTH-1:0] sra, single;
  logic [WIDTH:0] trial, diff;
  logic qbit, last;
  // single-cycle datapath and restoring-divider trial subtraction
  always_comb begin
    sra = $signed(i_a) >>> i_b;
    single = i_cmd == OP_SHL ? i_a << i_b :
             i_cmd == OP_SHR ? i_a >> i_b :
             i_cmd == OP_SHRA ? sra :
             i_cmd == OP_ADD ? i_a + i_b :
             i_cmd == OP_SUB ? i_a - i_b : i_a;
    trial = {acc_q, a_q[WIDTH-1]};
    diff = trial - {1'b0, b_q};
    qbit = ~diff[WIDTH];
    last = cnt_q == CW'(WIDTH - 1);
  end
  // next-state: accept in IDLE, iterate MUL (LSB first) / DIV (MSB first), one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    res_d = res_q;
    dz_d = dz_q;
    case (state_q)
      IDLE: if (i_valid) begin
        a_d = i_a;
        b_d = i_b;
        acc_d = '0;
        cnt_d = '0;
        if (i_cmd == OP_MUL) state_d = MUL;
        else if (i_cmd == OP_DIV) state_d = DIV;
        else begin
          res_d = single;
          dz_d = 1'b0;
          state_d = DONE;
        end
      end
      MUL: begin
        acc_d = b_q[0] ? acc_q + a_q : acc_q;
        a_d = a_q << 1;
        b_d = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          res_d = acc_d;
          dz_d = 1'b0;
          state_d = DONE;
        end
      end
      DIV: begin
        acc_d = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        a_d = {a_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          res_d = a_d;
          dz_d = b_q == '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      res_q <= res_d;
      dz_q <= dz_d;
    end
  end
  assign o_ready = state_q == IDLE;
  assign o_valid = state_q == DONE;
  assign o_result = res_q;
  assign o_div_zero = dz_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: randomized self-checking bench for alu_iter against an arithmetic reference model
module tb_alu_iter;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0, i_valid = 1'b0;
  logic [W-1:0] i_a = '0, i_b = '0, o_result;
  logic [2:0] i_cmd = '0;
  logic o_valid, o_ready, o_div_zero;
  int n_checks = 0, n_fail = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_a(i_a), .i_b(i_b), .i_cmd(i_cmd),
    .o_result(o_result), .o_valid(o_valid), .o_ready(o_ready), .o_div_zero(o_div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ext;
    logic [2*W-1:0] prod;
    case (c)
      3'd1: return {1'b0, (b >= W) ? {W{1'b0}} : a << b};
      3'd2: return {1'b0, (b >= W) ? {W{1'b0}} : a >> b};
      3'd3: begin
        ext = {{W{a[W-1]}}, a} >> ((b >= W) ? W : b);
        return {1'b0, ext[W-1:0]};
      end
      3'd4: return {1'b0, a + b};
      3'd5: return {1'b0, a - b};
      3'd6: begin
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return {1'b0, prod[W-1:0]};
      end
      3'd7: return (b == 0) ? {1'b1, {W{1'b1}}} : {1'b0, a / b};
      default: return {1'b0, a};
    endcase
  endfunction

  task automatic do_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit noise, input string nm);
    logic [W:0] exp_v;
    int lat, n;
    exp_v = model(c, a, b);
    lat = (c >= 3'd6) ? W + 1 : 1;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_before: got %b want 1", nm, o_ready); end
    i_valid = 1'b1; i_cmd = c; i_a = a; i_b = b;
    @(posedge clk);
    #1 i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_cmd = 3'($urandom);
    n = 1;
    @(negedge clk);
    while (!o_valid && n < 100) begin
      n_checks++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL %s busy_ready: got %b want 0 at cycle %0d", nm, o_ready, n); end
      if (noise) i_valid = 1'($urandom);
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL %s timeout: o_valid got %b want 1", nm, o_valid); end
    n_checks++;
    if (n != lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, n, lat); end
    n_checks++;
    if (o_result !== exp_v[W-1:0]) begin n_fail++; $display("FAIL %s result: got %h want %h", nm, o_result, exp_v[W-1:0]); end
    n_checks++;
    if (o_div_zero !== exp_v[W]) begin n_fail++; $display("FAIL %s div_zero: got %b want %b", nm, o_div_zero, exp_v[W]); end
    n_checks++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL %s done_ready: got %b want 0", nm, o_ready); end
    i_valid = noise ? 1'b1 : 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s pulse_end: valid %b ready %b want 0 1", nm, o_valid, o_ready);
    end
    n_checks++;
    if (o_result !== exp_v[W-1:0]) begin n_fail++; $display("FAIL %s result_hold: got %h want %h", nm, o_result, exp_v[W-1:0]); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== '0 || o_div_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: ready %b valid %b result %h dz %b want 1 0 0 0", o_ready, o_valid, o_result, o_div_zero);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== '0) begin
      n_fail++; $display("FAIL reset_release: ready %b valid %b result %h want 1 0 0", o_ready, o_valid, o_result);
    end
  endtask

  task automatic test_basic();
    do_op(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, "add_wrap");
    do_op(3'd5, 32'd0, 32'd1, 1'b0, "sub_wrap");
    do_op(3'd0, 32'hDEAD_BEEF, 32'h5, 1'b0, "nop");
  endtask

  task automatic test_shifts();
    do_op(3'd3, 32'h8000_0000, 32'd4, 1'b0, "shra4");
    do_op(3'd3, 32'h8000_0000, 32'd40, 1'b0, "shra40");
    do_op(3'd3, 32'h4000_0000, 32'd40, 1'b0, "shra40_pos");
    do_op(3'd2, 32'h8000_0000, 32'd40, 1'b0, "shr40");
    do_op(3'd2, 32'h8000_0000, 32'd31, 1'b0, "shr31");
    do_op(3'd1, 32'd1, 32'd31, 1'b0, "shl31");
    do_op(3'd1, 32'd1, 32'h1_0000, 1'b0, "shl_big");
  endtask

  task automatic test_mul();
    do_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mul_ones");
    do_op(3'd6, 32'd3, 32'd5, 1'b1, "mul_3x5");
    do_op(3'd6, $urandom, $urandom, 1'b1, "mul_rand");
  endtask

  task automatic test_div();
    do_op(3'd7, 32'd7, 32'd2, 1'b1, "div_7_2");
    do_op(3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, "div_by1");
    do_op(3'd7, 32'd5, 32'd0, 1'b0, "div_zero");
    do_op(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_big_b");
    do_op(3'd7, $urandom, 32'($urandom_range(1, 1000)), 1'b1, "div_rand");
  endtask

  task automatic test_reset_mid_op();
    int seen;
    @(negedge clk);
    i_valid = 1'b1; i_cmd = 3'd6; i_a = 32'd9; i_b = 32'd9;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: ready %b valid %b want 1 0", o_ready, o_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL midreset_novalid: got %0d pulses want 0", seen); end
    do_op(3'd0, 32'h1234, 32'd0, 1'b0, "nop_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    logic [W:0] e;
    int accepts = 0, valids = 0, cyc = 0;
    logic [2:0] c;
    logic [W-1:0] a, b;
    while ((accepts < 100 || q.size() != 0 || o_valid) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (o_valid) begin
        valids++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: o_valid with no outstanding request, result %h", o_result);
        end else begin
          e = q.pop_front();
          if ({o_div_zero, o_result} !== e) begin
            n_fail++; $display("FAIL b2b_result #%0d: got dz %b res %h want dz %b res %h", valids, o_div_zero, o_result, e[W], e[W-1:0]);
          end
        end
      end
      if (accepts < 100) begin
        c = 3'($urandom);
        a = $urandom;
        b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
        i_valid = 1'b1; i_cmd = c; i_a = a; i_b = b;
        if (o_ready) begin
          q.push_back(model(c, a, b));
          accepts++;
        end
      end else i_valid = 1'b0;
    end
    i_valid = 1'b0;
    n_checks++;
    if (cyc >= 6000) begin n_fail++; $display("FAIL b2b_timeout: %0d accepts %0d pending", accepts, q.size()); end
    n_checks++;
    if (accepts != valids) begin n_fail++; $display("FAIL b2b_count: valids %0d want %0d", valids, accepts); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shifts();
    test_mul();
    test_div();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
